// File: rtl/value_match_pkg.sv
// value_match_pkg: shared sizing helper and result record for the value match CAM.
package value_match_pkg;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic valid;
    logic hit;
    logic multi;
  } result_flags_t;
endpackage

// File: rtl/value_match_prio_enc.sv
// value_match_prio_enc: lowest-index priority encoder with hit and multiple-hit flags.
module value_match_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     match,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic             multi
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (match[i]) idx = IDX_W'(i);
  end
  assign hit = |match;
  // clearing the lowest set bit leaves something only when two or more bits were set
  assign multi = |(match & (match - N'(1)));
endmodule

// File: rtl/value_match_cam.sv
// value_match_cam: registered multi-port CAM with per-query skip masks,
// lowest-index/hit/multi results one cycle after the request.
module value_match_cam
  import value_match_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N       = 8,
  parameter int QUERIES = 2,
  parameter bit BYPASS  = 1'b1,
  localparam int IDX_W  = idx_width(N)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic                            i_wr_valid,
  input  logic [IDX_W-1:0]                i_wr_idx,
  input  logic [WIDTH-1:0]                i_wr_value,
  input  logic                            i_inv_valid,
  input  logic [IDX_W-1:0]                i_inv_idx,
  input  logic                            i_hold,
  input  logic [QUERIES-1:0]              i_q_valid,
  input  logic [QUERIES-1:0][WIDTH-1:0]   i_q_value,
  input  logic [QUERIES-1:0][N-1:0]       i_q_skip,
  output logic [QUERIES-1:0]              o_q_valid,
  output logic [QUERIES-1:0]              o_q_hit,
  output logic [QUERIES-1:0][IDX_W-1:0]   o_q_idx,
  output logic [QUERIES-1:0]              o_q_multi,
  output logic [IDX_W:0]                  o_count,
  output logic                            o_full
);
  typedef struct packed {
    result_flags_t    f;
    logic [IDX_W-1:0] idx;
  } result_t;
  logic [N-1:0][WIDTH-1:0]       value, nxt_value, eff_value;
  logic [N-1:0]                  valid, nxt_valid, eff_valid;
  logic [IDX_W:0]                count, nxt_count;
  logic                          full, wr_ok, inv_ok, inc, dec;
  logic [QUERIES-1:0][N-1:0]     match;
  logic [QUERIES-1:0]            hit, multi;
  logic [QUERIES-1:0][IDX_W-1:0] idx;
  result_t [QUERIES-1:0]         res_d, res_q;
  // flush drops the same-cycle write and invalidate; a write wins over an invalidate of its index
  assign wr_ok  = i_wr_valid && !i_flush && (int'(i_wr_idx) < N);
  assign inv_ok = i_inv_valid && !i_flush && (int'(i_inv_idx) < N) && !(wr_ok && i_wr_idx == i_inv_idx);
  assign inc = wr_ok && !valid[i_wr_idx];
  assign dec = inv_ok && valid[i_inv_idx];
  assign nxt_count = i_flush ? '0 : count + (IDX_W+1)'(inc) - (IDX_W+1)'(dec);
  always_comb begin
    nxt_valid = i_flush ? '0 : valid;
    nxt_value = value;
    if (inv_ok) nxt_valid[i_inv_idx] = 1'b0;
    if (wr_ok) begin
      nxt_valid[i_wr_idx] = 1'b1;
      nxt_value[i_wr_idx] = i_wr_value;
    end
  end
  assign eff_valid = BYPASS ? nxt_valid : valid;
  assign eff_value = BYPASS ? nxt_value : value;
  for (genvar q = 0; q < QUERIES; q++) begin : g_q
    for (genvar i = 0; i < N; i++) begin : g_m
      assign match[q][i] = eff_valid[i] & ~i_q_skip[q][i] & (eff_value[i] == i_q_value[q]);
    end
    value_match_prio_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
      .match (match[q]),
      .hit   (hit[q]),
      .idx   (idx[q]),
      .multi (multi[q])
    );
    assign res_d[q].f.valid = i_q_valid[q];
    assign res_d[q].f.hit   = i_q_valid[q] & hit[q];
    assign res_d[q].f.multi = i_q_valid[q] & multi[q];
    assign res_d[q].idx     = (i_q_valid[q] && hit[q]) ? idx[q] : '0;
    assign o_q_valid[q] = res_q[q].f.valid;
    assign o_q_hit[q]   = res_q[q].f.hit;
    assign o_q_multi[q] = res_q[q].f.multi;
    assign o_q_idx[q]   = res_q[q].idx;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= '0;
      value <= '0;
      count <= '0;
      full  <= 1'b0;
      res_q <= '0;
    end else begin
      valid <= nxt_valid;
      value <= nxt_value;
      count <= nxt_count;
      full  <= nxt_count == (IDX_W+1)'(N);
      if (!i_hold) res_q <= res_d;
    end
  end
  assign o_count = count;
  assign o_full  = full;
endmodule

// File: tb/tb_value_match_cam.sv
// tb_value_match_cam: random and directed stimulus on a BYPASS=1 and a BYPASS=0 CAM,
// checked every cycle against a behavioural table model.
module tb_value_match_cam;
  logic clk = 1'b0, rst_n = 1'b0;
  logic flush, wr_valid, inv_valid, hold;
  logic [2:0] wr_idx, inv_idx;
  logic [31:0] wr_value;
  logic [1:0] q_valid;
  logic [1:0][31:0] q_value;
  logic [1:0][7:0] q_skip;
  logic [1:0] o_qv [2];
  logic [1:0] o_hit [2];
  logic [1:0][2:0] o_idx [2];
  logic [1:0] o_multi [2];
  logic [3:0] o_cnt [2];
  logic o_full [2];
  int n_chk = 0, n_fail = 0;
  bit m_valid [8];
  logic [31:0] m_val [8];
  int e_cnt;
  bit e_v [2][2], e_h [2][2], e_m [2][2];
  int e_i [2][2];

  always #5 clk = ~clk;

  for (genvar b = 0; b < 2; b++) begin : g_dut
    value_match_cam #(.WIDTH(32), .N(8), .QUERIES(2), .BYPASS(b == 0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_wr_valid(wr_valid), .i_wr_idx(wr_idx), .i_wr_value(wr_value),
      .i_inv_valid(inv_valid), .i_inv_idx(inv_idx), .i_hold(hold),
      .i_q_valid(q_valid), .i_q_value(q_value), .i_q_skip(q_skip),
      .o_q_valid(o_qv[b]), .o_q_hit(o_hit[b]), .o_q_idx(o_idx[b]),
      .o_q_multi(o_multi[b]), .o_count(o_cnt[b]), .o_full(o_full[b])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) begin
      m_valid[i] = 0;
      m_val[i] = '0;
    end
    e_cnt = 0;
    for (int b = 0; b < 2; b++)
      for (int q = 0; q < 2; q++) begin
        e_v[b][q] = 0; e_h[b][q] = 0; e_m[b][q] = 0; e_i[b][q] = 0;
      end
  endtask

  // b=0 models the BYPASS=1 instance (sees the post-update table), b=1 the stored table
  task automatic model_update();
    bit pv [8], nv [8];
    logic [31:0] pval [8], nval [8];
    if (!rst_n) begin
      model_reset();
      return;
    end
    pv = m_valid; pval = m_val; nv = pv; nval = pval;
    if (flush) foreach (nv[i]) nv[i] = 0;
    else begin
      if (inv_valid && !(wr_valid && wr_idx == inv_idx)) nv[inv_idx] = 0;
      if (wr_valid) begin
        nv[wr_idx] = 1;
        nval[wr_idx] = wr_value;
      end
    end
    for (int b = 0; b < 2; b++)
      for (int q = 0; q < 2; q++) begin
        int n = 0, lo = 0;
        for (int i = 7; i >= 0; i--) begin
          bit v = (b == 0) ? nv[i] : pv[i];
          logic [31:0] x = (b == 0) ? nval[i] : pval[i];
          if (v && !q_skip[q][i] && x == q_value[q]) begin
            n++;
            lo = i;
          end
        end
        if (!hold) begin
          e_v[b][q] = q_valid[q];
          e_h[b][q] = q_valid[q] && n > 0;
          e_i[b][q] = (q_valid[q] && n > 0) ? lo : 0;
          e_m[b][q] = q_valid[q] && n > 1;
        end
      end
    m_valid = nv;
    m_val = nval;
    e_cnt = 0;
    foreach (nv[i]) e_cnt += int'(nv[i]);
  endtask

  task automatic compare();
    for (int b = 0; b < 2; b++) begin
      for (int q = 0; q < 2; q++) begin
        chk($sformatf("b%0d_q%0d_valid", b, q), o_qv[b][q], e_v[b][q]);
        chk($sformatf("b%0d_q%0d_hit", b, q), o_hit[b][q], e_h[b][q]);
        chk($sformatf("b%0d_q%0d_idx", b, q), o_idx[b][q], e_i[b][q]);
        chk($sformatf("b%0d_q%0d_multi", b, q), o_multi[b][q], e_m[b][q]);
      end
      chk($sformatf("b%0d_count", b), o_cnt[b], e_cnt);
      chk($sformatf("b%0d_full", b), o_full[b], e_cnt == 8);
    end
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    flush = 0; wr_valid = 0; inv_valid = 0; hold = 0;
    wr_idx = '0; inv_idx = '0; wr_value = '0;
    q_valid = '0; q_value = '0; q_skip = '0;
  endtask

  task automatic write(input int idx, input logic [31:0] v);
    wr_valid = 1;
    wr_idx = 3'(idx);
    wr_value = v;
  endtask

  initial begin
    idle();
    model_reset();
    step();
    step();
    chk("rst_count", o_cnt[0], 0);
    chk("rst_valid", o_qv[0], 0);
    rst_n = 1;
    write(3, 32'h55); step();
    idle(); write(5, 32'h55); step();
    idle(); q_valid = 2'b11; q_value[0] = 32'h55; q_value[1] = 32'h55; q_skip[1] = 8'h08; step();
    chk("two_hit", o_hit[0][0], 1);
    chk("two_idx", o_idx[0][0], 3);
    chk("two_multi", o_multi[0][0], 1);
    chk("skip3_idx", o_idx[0][1], 5);
    chk("skip3_multi", o_multi[0][1], 0);
    chk("two_count", o_cnt[0], 2);
    idle(); q_valid = 2'b01; q_value[0] = 32'h55; q_skip[0] = 8'h28; step();
    chk("skip35_hit", o_hit[0][0], 0);
    chk("skip35_idx", o_idx[0][0], 0);
    idle(); write(0, 32'hAA); q_valid = 2'b01; q_value[0] = 32'hAA; step();
    chk("bypass_hit", o_hit[0][0], 1);
    chk("bypass_idx", o_idx[0][0], 0);
    chk("nobypass_hit", o_hit[1][0], 0);
    idle(); write(2, 32'h11); inv_valid = 1; inv_idx = 3'd2; step();
    chk("wr_inv_count", o_cnt[0], 4);
    idle(); flush = 1; write(1, 32'h77); q_valid = 2'b01; q_value[0] = 32'h55; step();
    chk("flush_count", o_cnt[0], 0);
    chk("flush_bypass_hit", o_hit[0][0], 0);
    chk("flush_stored_hit", o_hit[1][0], 1);
    idle(); q_valid = 2'b01; q_value[0] = 32'h77; step();
    chk("flush_wr_dropped", o_hit[0][0], 0);
    for (int i = 0; i < 8; i++) begin
      idle(); write(i, 32'(i)); step();
    end
    chk("fill_full", o_full[0], 1);
    chk("fill_count", o_cnt[0], 8);
    idle(); inv_valid = 1; inv_idx = 3'd7; step();
    chk("inv7_count", o_cnt[0], 7);
    chk("inv7_full", o_full[0], 0);
    step();
    chk("inv7_again_count", o_cnt[0], 7);
    idle(); q_valid = 2'b01; q_value[0] = 32'd3; step();
    chk("prehold_idx", o_idx[0][0], 3);
    hold = 1; q_valid = 2'b11; q_value[0] = 32'd5; q_value[1] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_hit", o_hit[0][0], 1);
      chk("hold_idx", o_idx[0][0], 3);
      chk("hold_q1_valid", o_qv[0][1], 0);
    end
    #2 rst_n = 0;
    #1 model_reset();
    for (int b = 0; b < 2; b++) begin
      chk("async_rst_valid", o_qv[b], 0);
      chk("async_rst_hit", o_hit[b], 0);
      chk("async_rst_idx", o_idx[b], 0);
      chk("async_rst_count", o_cnt[b], 0);
    end
    @(negedge clk);
    compare();
    step();
    rst_n = 1;
    idle();
    repeat (1500) begin
      flush = ($urandom % 32) == 0;
      wr_valid = ($urandom % 2) == 0;
      wr_idx = 3'($urandom);
      wr_value = $urandom % 4;
      inv_valid = ($urandom % 3) == 0;
      inv_idx = 3'($urandom);
      hold = ($urandom % 8) == 0;
      q_valid = 2'($urandom);
      for (int q = 0; q < 2; q++) begin
        q_value[q] = $urandom % 4;
        q_skip[q] = (($urandom % 4) == 0) ? 8'($urandom) : 8'h00;
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
